frigate_adc_sar_ctrl: RTL and testbench
=======================================

FRIGATE_ADC_SAR_CTRL -- requirements
Module: frigate_adc_sar_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_CYCLES, default 4, range 1..255: number of CLK cycles the selected channel is tracked before hold.
REQ-002 SHALL have parameter NBITS, default 12, fixed at 12: conversion width.
REQ-003 SHALL have port CLK  input  1  the only clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port START  input  1  one-cycle request to begin a scan.
REQ-006 SHALL have port ABORT  input  1  terminates any scan in progress.
REQ-007 SHALL have port CH_MASK  input  8  channels to convert; bit n enables channel n.
REQ-008 SHALL have port CMP  input  1  comparator result from the ADC macro; 1 means held input > DAC level.
REQ-009 SHALL have port ADC_EN  output  1  ADC macro enable.
REQ-010 SHALL have port ADC_RST  output  1  ADC macro reset.
REQ-011 SHALL have port HOLD  output  1  sample/hold control; the rising edge captures the input.
REQ-012 SHALL have port B  output  3  channel select to the ADC macro.
REQ-013 SHALL have port DATA  output  12  DAC trial code.
REQ-014 SHALL have port RESULT  output  12  converted code.
REQ-015 SHALL have port RESULT_CH  output  3  channel of RESULT.
REQ-016 SHALL have port VALID  output  1  RESULT and RESULT_CH are valid.
REQ-017 SHALL have port READY  input  1  consumer accepts the result.
REQ-018 SHALL have port BUSY  output  1  a scan is in progress.

Function
REQ-019 SHALL implement FSM states IDLE, SAMPLE, CONVERT, OUTPUT, NEXT.
REQ-020 IDLE: ADC_RST=1, ADC_EN=0, HOLD=0, BUSY=0; a START with CH_MASK!=0 SHALL latch CH_MASK, select the lowest set channel on B, and enter SAMPLE; a START with CH_MASK==0 SHALL be ignored.
REQ-021 SAMPLE: ADC_EN=1, ADC_RST=0, HOLD=0, DATA=0 for exactly SAMPLE_CYCLES cycles, then CONVERT.
REQ-022 CONVERT: HOLD=1 throughout; 12 cycles, bit i=11 down to 0; in each cycle DATA = accumulated bits | (1<<i); at the end of that cycle bit i SHALL be kept iff CMP=1.
REQ-023 After bit 0, the FSM SHALL register RESULT and RESULT_CH, assert VALID, drop HOLD, and enter OUTPUT.
REQ-024 Latency: START accepted in cycle 0 -> HOLD rises in cycle SAMPLE_CYCLES+1 -> VALID in cycle SAMPLE_CYCLES+13.
REQ-025 OUTPUT: VALID, RESULT and RESULT_CH SHALL be held stable until VALID&&READY; the transfer completes on that cycle, then NEXT.
REQ-026 NEXT: select the next higher set channel of the latched mask and enter SAMPLE; if none remains, enter IDLE.
REQ-027 START while BUSY SHALL be ignored; CH_MASK changes during a scan SHALL have no effect.
REQ-028 ABORT SHALL force IDLE on the next edge from any state and clear VALID, with no partial result emitted; ABORT has priority over START and READY.
REQ-029 BUSY SHALL be 1 in every state except IDLE.

Reset
REQ-030 RST SHALL force state IDLE, HOLD=0, ADC_EN=0, ADC_RST=1, B=0, DATA=0, RESULT=0, RESULT_CH=0, VALID=0, BUSY=0 and clear the latched mask, including when asserted mid-conversion.
REQ-031 RST SHALL have priority over ABORT and START.

Configuration
REQ-032 With macro FRIGATE_ADC_CTRL_CONT_EN defined, an extra input port CONT (1 bit) SHALL exist; when CONT=1 and the last channel completes, NEXT SHALL restart at the lowest latched channel instead of entering IDLE, until ABORT or RST.
REQ-033 Without FRIGATE_ADC_CTRL_CONT_EN, port CONT SHALL be absent and every scan SHALL end in IDLE.

Verification (bench CMP model: CMP = (2*DATA < 2*X+1), X = per-channel code)
REQ-034 Single channel: CH_MASK=0x01, X=0xA5C, READY=1, START -> VALID in cycle 17 with RESULT=0xA5C, RESULT_CH=0, then IDLE.
REQ-035 Extremes: X=0x000 -> RESULT=0x000; X=0xFFF -> RESULT=0xFFF; HOLD high for exactly 12 cycles in each case.
REQ-036 Scan with backpressure: CH_MASK=0x94 (X2=0x123, X4=0x800, X7=0x7FF), READY low for 5 cycles per result -> results in order ch2, ch4, ch7 with those codes; RESULT held stable while stalled.
REQ-037 Abort and reset: ABORT at conversion bit 6 -> IDLE next cycle, no VALID; RST in SAMPLE -> all outputs at reset values next cycle; START with CH_MASK=0 -> BUSY stays 0.
REQ-038 With FRIGATE_ADC_CTRL_CONT_EN and CONT=1, CH_MASK=0x03 -> results ch0, ch1, ch0, ch1 ... until ABORT, after which BUSY=0.

Source files
------------

// File: rtl/frigate_adc_sar_ctrl.sv
// ---------------------------------------------------------------------------
// frigate_adc_sar_ctrl
//
// Successive-approximation ADC sequencer. It scans the channels enabled in a
// latched channel mask in ascending order. For each channel it tracks the
// input for SAMPLE_CYCLES cycles and then resolves NBITS bits MSB-first
// against the comparator. Each result is presented with a VALID/READY
// handshake.
//
// Optional feature (compile-time macro FRIGATE_ADC_CTRL_CONT_EN):
//   Adds input CONT. While CONT=1, a finished scan restarts at the lowest
//   latched channel instead of returning to IDLE.
//
// Ports:
//   CLK        in   single clock, rising edge
//   RST        in   synchronous active-high reset
//   START      in   one-cycle scan request (ignored while busy or mask==0)
//   ABORT      in   returns to IDLE on the next edge, discarding any result
//   CH_MASK    in   [7:0] channel enable mask, sampled on an accepted START
//   CMP        in   comparator: 1 when held input > DAC level
//   ADC_EN     out  ADC macro enable (high outside IDLE)
//   ADC_RST    out  ADC macro reset (high in IDLE)
//   HOLD       out  sample/hold control, high during conversion
//   B          out  [2:0] channel select
//   DATA       out  [NBITS-1:0] DAC trial code
//   RESULT     out  [NBITS-1:0] converted code
//   RESULT_CH  out  [2:0] channel of RESULT
//   VALID      out  RESULT/RESULT_CH valid
//   READY      in   consumer accepts the result
//   CONT       in   continuous scan (only with FRIGATE_ADC_CTRL_CONT_EN)
//   BUSY       out  scan in progress (any state but IDLE)
//
// All outputs come directly from registers. Each output register is loaded
// from the next-state value, so it lines up with the state it describes.
// ---------------------------------------------------------------------------
module frigate_adc_sar_ctrl #(
  parameter int SAMPLE_CYCLES = 4,
  parameter int NBITS         = 12
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [7:0]       CH_MASK,
  input  logic             CMP,
  output logic             ADC_EN,
  output logic             ADC_RST,
  output logic             HOLD,
  output logic [2:0]       B,
  output logic [NBITS-1:0] DATA,
  output logic [NBITS-1:0] RESULT,
  output logic [2:0]       RESULT_CH,
  output logic             VALID,
  input  logic             READY,
`ifdef FRIGATE_ADC_CTRL_CONT_EN
  input  logic             CONT,
`endif
  output logic             BUSY
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SAMPLE  = 3'd1,
    CONVERT = 3'd2,
    OUTPUT  = 3'd3,
    NEXT    = 3'd4
  } state_t;

  localparam logic [NBITS-1:0] ZERO_CODE   = {NBITS{1'b0}};
  localparam logic [NBITS-1:0] MSB_CODE    = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [7:0]       SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);

  // Index of the lowest set bit of a channel mask (0 when the mask is empty).
  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    logic [2:0] ch;
    ch = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) begin
        ch = 3'(i);
      end else begin
        ch = ch;
      end
    end
    return ch;
  endfunction

  // One-hot mask bit for a channel number.
  function automatic logic [7:0] ch_bit(input logic [2:0] ch);
    return 8'd1 << ch;
  endfunction

  state_t           state_r;
  state_t           nxt_state_s;
  logic [7:0]       cnt_r;
  logic [7:0]       nxt_cnt_s;
  logic [NBITS-1:0] trial_r;      // one-hot: bit currently being resolved
  logic [NBITS-1:0] nxt_trial_s;
  logic [NBITS-1:0] data_r;
  logic [NBITS-1:0] nxt_data_s;
  logic [NBITS-1:0] acc_s;        // code after resolving the current bit
  logic [NBITS-1:0] result_r;
  logic [NBITS-1:0] nxt_result_s;
  logic [2:0]       result_ch_r;
  logic [2:0]       nxt_result_ch_s;
  logic [2:0]       b_r;
  logic [2:0]       nxt_b_s;
  logic [7:0]       mask_r;       // mask latched at START (for restarts)
  logic [7:0]       nxt_mask_s;
  logic [7:0]       rem_r;        // channels still to convert in this pass
  logic [7:0]       nxt_rem_s;
  logic             hold_r;
  logic             adc_en_r;
  logic             adc_rst_r;
  logic             valid_r;
  logic             busy_r;
  logic             cont_s;

`ifdef FRIGATE_ADC_CTRL_CONT_EN
  assign cont_s = CONT;
`else
  assign cont_s = 1'b0;
`endif

  // Resolve the current trial bit: keep it only when the comparator says the
  // held input is above the trial level.
  always_comb begin
    acc_s = data_r;
    if (CMP) begin
      acc_s = data_r;
    end else begin
      acc_s = data_r & ~trial_r;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    nxt_state_s     = state_r;
    nxt_cnt_s       = cnt_r;
    nxt_trial_s     = trial_r;
    nxt_data_s      = ZERO_CODE;
    nxt_result_s    = result_r;
    nxt_result_ch_s = result_ch_r;
    nxt_b_s         = b_r;
    nxt_mask_s      = mask_r;
    nxt_rem_s       = rem_r;

    if (ABORT) begin
      // Abort wins over START and READY; any partial result is discarded.
      nxt_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (START && (CH_MASK != 8'd0)) begin
            nxt_mask_s  = CH_MASK;
            nxt_b_s     = lowest_ch(CH_MASK);
            nxt_rem_s   = CH_MASK & ~ch_bit(lowest_ch(CH_MASK));
            nxt_cnt_s   = 8'd0;
            nxt_state_s = SAMPLE;
          end else begin
            nxt_state_s = IDLE;
          end
        end

        SAMPLE: begin
          if (cnt_r == SAMPLE_LAST) begin
            nxt_trial_s = MSB_CODE;
            nxt_data_s  = MSB_CODE;
            nxt_state_s = CONVERT;
          end else begin
            nxt_cnt_s = cnt_r + 8'd1;
          end
        end

        CONVERT: begin
          if (trial_r[0]) begin
            nxt_result_s    = acc_s;
            nxt_result_ch_s = b_r;
            nxt_state_s     = OUTPUT;
          end else begin
            // Present the resolved upper bits plus the next trial bit.
            nxt_trial_s = trial_r >> 1;
            nxt_data_s  = acc_s | (trial_r >> 1);
          end
        end

        OUTPUT: begin
          if (READY) begin
            nxt_state_s = NEXT;
          end else begin
            nxt_state_s = OUTPUT;
          end
        end

        NEXT: begin
          if (rem_r != 8'd0) begin
            nxt_b_s     = lowest_ch(rem_r);
            nxt_rem_s   = rem_r & ~ch_bit(lowest_ch(rem_r));
            nxt_cnt_s   = 8'd0;
            nxt_state_s = SAMPLE;
          end else if (cont_s) begin
            nxt_b_s     = lowest_ch(mask_r);
            nxt_rem_s   = mask_r & ~ch_bit(lowest_ch(mask_r));
            nxt_cnt_s   = 8'd0;
            nxt_state_s = SAMPLE;
          end else begin
            nxt_state_s = IDLE;
          end
        end

        default: begin
          nxt_state_s = IDLE;
        end
      endcase
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      cnt_r       <= 8'd0;
      trial_r     <= ZERO_CODE;
      data_r      <= ZERO_CODE;
      result_r    <= ZERO_CODE;
      result_ch_r <= 3'd0;
      b_r         <= 3'd0;
      mask_r      <= 8'd0;
      rem_r       <= 8'd0;
      hold_r      <= 1'b0;
      adc_en_r    <= 1'b0;
      adc_rst_r   <= 1'b1;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= nxt_state_s;
      cnt_r       <= nxt_cnt_s;
      trial_r     <= nxt_trial_s;
      data_r      <= nxt_data_s;
      result_r    <= nxt_result_s;
      result_ch_r <= nxt_result_ch_s;
      b_r         <= nxt_b_s;
      mask_r      <= nxt_mask_s;
      rem_r       <= nxt_rem_s;
      hold_r      <= (nxt_state_s == CONVERT);
      adc_en_r    <= (nxt_state_s != IDLE);
      adc_rst_r   <= (nxt_state_s == IDLE);
      valid_r     <= (nxt_state_s == OUTPUT);
      busy_r      <= (nxt_state_s != IDLE);
    end
  end

  assign ADC_EN    = adc_en_r;
  assign ADC_RST   = adc_rst_r;
  assign HOLD      = hold_r;
  assign B         = b_r;
  assign DATA      = data_r;
  assign RESULT    = result_r;
  assign RESULT_CH = result_ch_r;
  assign VALID     = valid_r;
  assign BUSY      = busy_r;

endmodule

// File: tb/tb_frigate_adc_sar_ctrl.sv
// ---------------------------------------------------------------------------
// tb_frigate_adc_sar_ctrl
//
// Self-checking bench. It models the ADC as an ideal comparator against a
// per-channel code X: CMP = (2*DATA < 2*X+1). An ideal SAR therefore returns
// X. Expected results are derived from the channel mask order and the X
// table. Expected DAC trial codes come from the resolved upper bits of X plus
// the current trial bit.
// ---------------------------------------------------------------------------
module tb_frigate_adc_sar_ctrl;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  ch_mask;
  logic        cmp;
  logic        adc_en;
  logic        adc_rst;
  logic        hold;
  logic [2:0]  b;
  logic [11:0] data;
  logic [11:0] result;
  logic [2:0]  result_ch;
  logic        valid;
  logic        ready;
  logic        busy;
`ifdef FRIGATE_ADC_CTRL_CONT_EN
  logic        cont;
`endif

  logic [11:0] chan_x [8];
  int          vec_cnt = 0;
  int          err_cnt = 0;

  frigate_adc_sar_ctrl #(.SAMPLE_CYCLES(SC), .NBITS(12)) dut (
    .CLK(clk), .RST(rst), .START(start), .ABORT(abort), .CH_MASK(ch_mask),
    .CMP(cmp), .ADC_EN(adc_en), .ADC_RST(adc_rst), .HOLD(hold), .B(b),
    .DATA(data), .RESULT(result), .RESULT_CH(result_ch), .VALID(valid),
    .READY(ready),
`ifdef FRIGATE_ADC_CTRL_CONT_EN
    .CONT(cont),
`endif
    .BUSY(busy)
  );

  always #5 clk = ~clk;

  // Ideal comparator model of the ADC macro.
  assign cmp = ({data, 1'b0} < {chan_x[b], 1'b1});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vec_cnt++;
    if (obs !== want) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_hold"}, hold, 1'b0);
    check({tag, "_adc_en"}, adc_en, 1'b0);
    check({tag, "_adc_rst"}, adc_rst, 1'b1);
    check({tag, "_b"}, b, 3'd0);
    check({tag, "_data"}, data, 12'd0);
    check({tag, "_result"}, result, 12'd0);
    check({tag, "_result_ch"}, result_ch, 3'd0);
    check({tag, "_valid"}, valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  // Start a scan and check nres results. Channels repeat cyclically when
  // nres exceeds the mask population, which models continuous mode.
  task automatic run_scan(input logic [7:0] mask, input int stall, input int nres,
                          input bit expect_idle);
    int q[$];
    int cyc;
    int hold_cnt;
    int guard;
    int want_ch;
    int i;
    logic [31:0] x;
    logic [31:0] want_data;
    logic [11:0] held_res;
    logic [2:0]  held_ch;
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) q.push_back(c);
    end
    start   = 1'b1;
    ch_mask = mask;
    ready   = (stall == 0);
    tick();
    start = 1'b0;
    cyc   = 1;
    for (int r = 0; r < nres; r++) begin
      want_ch  = q[r % q.size()];
      x        = 32'(chan_x[want_ch]);
      hold_cnt = 0;
      guard    = 0;
      while (!valid && guard < 200) begin
        check("busy_in_scan", busy, 1'b1);
        if (hold) begin
          check("b_during_conv", b, want_ch);
          if (hold_cnt < 12) begin
            i = 11 - hold_cnt;
            want_data = (x & ~((32'd1 << (i + 1)) - 32'd1)) | (32'd1 << i);
            check("dac_trial", data, want_data);
          end
          hold_cnt++;
        end else begin
          check("dac_not_hold", data, 12'd0);
        end
        // Busy-time START and mask changes must be ignored.
        start   = ($urandom_range(0, 7) == 0);
        ch_mask = 8'($urandom);
        tick();
        cyc++;
        guard++;
      end
      start = 1'b0;
      check("valid_seen", valid, 1'b1);
      if (!valid) return;
      if (r == 0) check("valid_latency", cyc, SC + 13);
      check("hold_cycles", hold_cnt, 12);
      check("result_ch", result_ch, want_ch);
      check("result", result, x);
      held_res = result;
      held_ch  = result_ch;
      for (int s = 0; s < stall; s++) begin
        tick();
        check("stall_valid", valid, 1'b1);
        check("stall_result", result, held_res);
        check("stall_ch", result_ch, held_ch);
      end
      ready = 1'b1;
      tick();
      check("valid_drop", valid, 1'b0);
      ready = (stall == 0);
    end
    ready = 1'b1;
    if (expect_idle) begin
      tick();
      check("idle_after_scan", busy, 1'b0);
    end
  endtask

  initial begin
    int guard;
    int vcount;
    logic [7:0] m;
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    ch_mask = 8'd0;
    ready = 1'b1;
`ifdef FRIGATE_ADC_CTRL_CONT_EN
    cont = 1'b0;
`endif
    for (int c = 0; c < 8; c++) chan_x[c] = 12'd0;
    tick();
    tick();
    check_reset_state("reset");
    rst = 1'b0;
    tick();

    // Single channel, then extremes.
    chan_x[0] = 12'hA5C;
    run_scan(8'h01, 0, 1, 1'b1);
    chan_x[0] = 12'h000;
    run_scan(8'h01, 0, 1, 1'b1);
    chan_x[0] = 12'hFFF;
    run_scan(8'h01, 0, 1, 1'b1);

    // Multi-channel scan with backpressure.
    chan_x[2] = 12'h123;
    chan_x[4] = 12'h800;
    chan_x[7] = 12'h7FF;
    run_scan(8'h94, 5, 3, 1'b1);

    // START with an empty mask is ignored.
    start = 1'b1;
    ch_mask = 8'h00;
    tick();
    start = 1'b0;
    check("empty_mask_busy", busy, 1'b0);
    tick();
    check("empty_mask_busy2", busy, 1'b0);

    // ABORT beats a simultaneous START.
    start = 1'b1;
    abort = 1'b1;
    ch_mask = 8'h01;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_vs_start", busy, 1'b0);

    // ABORT at conversion bit 6.
    chan_x[1] = 12'h5A5;
    start = 1'b1;
    ch_mask = 8'h02;
    tick();
    start = 1'b0;
    guard = 0;
    while (!hold && guard < 50) begin
      tick();
      guard++;
    end
    check("abort_hold_seen", hold, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    check("abort_bit6_data", data, 12'h5C0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_hold", hold, 1'b0);
    check("abort_adc_rst", adc_rst, 1'b1);
    check("abort_valid", valid, 1'b0);
    vcount = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (valid) vcount++;
    end
    check("abort_no_valid", vcount, 0);

    // ABORT while a result is waiting clears VALID.
    chan_x[0] = 12'h3C1;
    ready = 1'b0;
    start = 1'b1;
    ch_mask = 8'h01;
    tick();
    start = 1'b0;
    guard = 0;
    while (!valid && guard < 50) begin
      tick();
      guard++;
    end
    check("out_abort_valid_seen", valid, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ready = 1'b1;
    check("out_abort_valid", valid, 1'b0);
    check("out_abort_busy", busy, 1'b0);

    // RST during SAMPLE (RESULT holds 0x3C1 and B will be 7 beforehand).
    start = 1'b1;
    ch_mask = 8'h80;
    tick();
    start = 1'b0;
    tick();
    check("pre_rst_b", b, 3'd7);
    rst = 1'b1;
    abort = 1'b1;
    tick();
    rst = 1'b0;
    abort = 1'b0;
    check_reset_state("rst_sample");

    // Randomized scans.
    for (int n = 0; n < 10; n++) begin
      for (int c = 0; c < 8; c++) chan_x[c] = 12'($urandom);
      m = 8'($urandom_range(1, 255));
      run_scan(m, $urandom_range(0, 3), $countones(m), 1'b1);
    end

`ifdef FRIGATE_ADC_CTRL_CONT_EN
    // Continuous scan: ch0, ch1, ch0, ch1, ... until ABORT.
    chan_x[0] = 12'h111;
    chan_x[1] = 12'hEEE;
    cont = 1'b1;
    run_scan(8'h03, 0, 6, 1'b0);
    check("cont_still_busy", busy, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    cont = 1'b0;
    check("cont_abort_busy", busy, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
